// File: rtl/transpose_read_controller.sv
`default_nettype none
// ============================================================================
// transpose_read_controller
//   Issues diagonal bank reads, un-rotates the data and streams transposed rows.
// Revision: 1.0
// ============================================================================
module transpose_read_controller #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 8,
  parameter int NUM_PE     = NUM_MG
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [$clog2(NUM_PE)-1:0]   read_addr [0:NUM_MG-1],
  input  logic [DATA_WIDTH-1:0]       read_data [0:NUM_MG-1],
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [DATA_WIDTH-1:0]       output_row [0:NUM_PE-1]
);

  localparam int ADDR_WIDTH = $clog2(NUM_PE);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(NUM_PE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   col_q;
  logic [ADDR_WIDTH-1:0]   tag_q;
  logic                    inflight_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   addr_q [0:NUM_MG-1];
  logic [DATA_WIDTH-1:0]   fifo_q [0:1][0:NUM_PE-1];
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [1:0]              count_q;

  logic                    pop;
  logic                    push;
  logic [2:0]              occupancy;
  logic [1:0]              count_d;
  logic [DATA_WIDTH-1:0]   rot_row [0:NUM_PE-1];

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign out_val = (count_q != 2'd0);
  assign pop     = out_val & out_rdy;
  assign push    = inflight_q;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  // Occupancy after this cycle's pop; a new read is only safe if it leaves room for its data.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = (state_q == READ) && (occupancy <= 3'd1);

  always_comb begin
    for (int b = 0; b < NUM_MG; b++) begin
      read_addr[b] = rd_en ? (ADDR_WIDTH'(b) - col_q) : addr_q[b];
    end
  end

  // Row element r of column c lives in bank (r + c) mod NUM_PE.
  always_comb begin
    for (int r = 0; r < NUM_PE; r++) begin
      rot_row[r] = read_data[ADDR_WIDTH'(r) + tag_q];
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_PE; r++) begin
      output_row[r] = fifo_q[rd_ptr_q][r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int b = 0; b < NUM_MG; b++) begin
        addr_q[b] <= '0;
      end
      for (int e = 0; e < 2; e++) begin
        for (int r = 0; r < NUM_PE; r++) begin
          fifo_q[e][r] <= '0;
        end
      end
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_en;
      count_q    <= count_d;
      for (int b = 0; b < NUM_MG; b++) begin
        addr_q[b] <= read_addr[b];
      end

      if (rd_en) begin
        tag_q <= col_q;
        if (col_q != LAST_COL) begin
          col_q <= col_q + 1'b1;
        end
      end

      if (push) begin
        for (int r = 0; r < NUM_PE; r++) begin
          fifo_q[wr_ptr_q][r] <= rot_row[r];
        end
        wr_ptr_q <= ~wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            col_q   <= '0;
          end
        end
        READ: begin
          if (rd_en && (col_q == LAST_COL)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight_q && (count_d == 2'd0)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transpose_read_controller.sv
`default_nettype none
// ============================================================================
// tb_transpose_read_controller
//   Randomized and directed scenarios against a skewed-bank matrix model.
// Revision: 1.0
// ============================================================================
module tb_transpose_read_controller;

  localparam int N  = 8;
  localparam int DW = 64;
  localparam int AW = $clog2(N);

  typedef logic [N*DW-1:0] prow_t;
  typedef logic [N*AW-1:0] paddr_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [AW-1:0]   read_addr [0:N-1];
  logic [DW-1:0]   read_data [0:N-1];
  logic            out_val;
  logic            out_rdy;
  logic [DW-1:0]   output_row [0:N-1];

  logic [DW-1:0]   mat  [0:N-1][0:N-1];
  logic [DW-1:0]   bank [0:N-1][0:N-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  transpose_read_controller #(
    .DATA_WIDTH (DW),
    .NUM_MG     (N),
    .NUM_PE     (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .output_row (output_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank memories with one cycle of read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < N; b++) read_data[b] <= '0;
    end else if (rd_en) begin
      for (int b = 0; b < N; b++) read_data[b] <= bank[b][read_addr[b]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind 1: A = 16r+c, kind 2: B = 200+8r+c, other: random
  task automatic load_matrix(input int kind);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (kind)
          1:       mat[r][c] = DW'(16 * r + c);
          2:       mat[r][c] = DW'(200 + 8 * r + c);
          default: mat[r][c] = {$urandom, $urandom};
        endcase
        bank[(c + r) % N][r] = mat[r][c];
      end
    end
  endtask

  function automatic prow_t exp_row(input int c);
    prow_t v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = mat[r][c];
    return v;
  endfunction

  function automatic prow_t pack_row();
    prow_t v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = output_row[r];
    return v;
  endfunction

  function automatic paddr_t exp_addr(input int c);
    paddr_t v;
    for (int b = 0; b < N; b++) v[b*AW +: AW] = AW'(b - c);
    return v;
  endfunction

  function automatic paddr_t pack_addr();
    paddr_t v;
    for (int b = 0; b < N; b++) v[b*AW +: AW] = read_addr[b];
    return v;
  endfunction

  // Advance one cycle, drive inputs for the new cycle, then settle for sampling.
  task automatic step(input logic st, input logic rdy, input logic rs);
    @(posedge clk);
    #1;
    start   = st;
    out_rdy = rdy;
    rst     = rs;
    #1;
  endtask

  // Assumes start=1 is being driven in the current cycle T; runs until done.
  task automatic run_readout(input string nm, input int mode, input int restart_k,
                             input int chain_kind, output int first_k, output int last_k,
                             output int done_k, output int rd_mask);
    int     rows;
    int     issues;
    logic   rdy;
    bit     prev_stall;
    bit     have_prev;
    prow_t  prev_row;
    paddr_t prev_addr;
    rows = 0; issues = 0; first_k = -1; last_k = -1; done_k = -1; rd_mask = 0;
    prev_stall = 0; have_prev = 0; prev_row = '0; prev_addr = '0;
    for (int k = 1; k <= 200; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(k >= 3 && k <= 8);
        2:       rdy = (k % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      step(k == restart_k, rdy, 1'b0);
      total_cnt++;
      if (issues - rows > 2)
        $display("FAIL %s occupancy k=%0d: got %0d outstanding, required <= 2", nm, k, issues - rows);
      else pass_cnt++;
      if (prev_stall) begin
        total_cnt++;
        if (out_val !== 1'b1 || pack_row() !== prev_row)
          $display("FAIL %s stall_hold k=%0d: got val=%b row=%h required val=1 row=%h",
                   nm, k, out_val, pack_row(), prev_row);
        else pass_cnt++;
      end
      if (rd_en === 1'b1) begin
        if (k < 32) rd_mask |= (1 << k);
        total_cnt++;
        if (pack_addr() !== exp_addr(issues))
          $display("FAIL %s read_addr k=%0d: got %h required %h", nm, k, pack_addr(), exp_addr(issues));
        else pass_cnt++;
        issues++;
      end else if (have_prev) begin
        total_cnt++;
        if (pack_addr() !== prev_addr)
          $display("FAIL %s addr_hold k=%0d: got %h required %h", nm, k, pack_addr(), prev_addr);
        else pass_cnt++;
      end
      if (out_val === 1'b1 && rdy) begin
        total_cnt++;
        if (rows >= N || pack_row() !== exp_row(rows))
          $display("FAIL %s row%0d k=%0d: got %h required %h", nm, rows, k, pack_row(), exp_row(rows % N));
        else pass_cnt++;
        if (first_k < 0) first_k = k;
        last_k = k;
        rows++;
      end
      prev_stall = (out_val === 1'b1) && !rdy;
      prev_row   = pack_row();
      prev_addr  = pack_addr();
      have_prev  = 1;
      if (done === 1'b1) begin
        done_k = k;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b required 0", nm, busy);
        else pass_cnt++;
        if (chain_kind != 0) begin
          start = 1'b1;
          load_matrix(chain_kind);
        end
        break;
      end
    end
    total_cnt++;
    if (rows !== N) $display("FAIL %s row_count: got %0d required %0d", nm, rows, N);
    else pass_cnt++;
    total_cnt++;
    if (done_k < 0 || done_k !== last_k + 1)
      $display("FAIL %s done_timing: got cycle %0d required %0d", nm, done_k, last_k + 1);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if ({busy, done, rd_en, out_val} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b required 0000", {busy, done, rd_en, out_val});
    else pass_cnt++;
    total_cnt++;
    if (pack_addr() !== '0) $display("FAIL reset_addr: got %h required 0", pack_addr());
    else pass_cnt++;
    total_cnt++;
    if (pack_row() !== '0) $display("FAIL reset_row: got %h required 0", pack_row());
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    int f, l, d, m;
    load_matrix(1);
    step(1'b1, 1'b1, 1'b0);
    run_readout("basic", 0, 0, 0, f, l, d, m);
    total_cnt++;
    if (f !== 3 || l !== 3 + N - 1 || d !== 3 + N)
      $display("FAIL basic_latency: got first=%0d last=%0d done=%0d required 3/%0d/%0d", f, l, d, 2 + N, 3 + N);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int f, l, d, m;
    load_matrix(1);
    step(1'b1, 1'b1, 1'b0);
    run_readout("stall", 1, 0, 0, f, l, d, m);
    total_cnt++;
    if ((m & 32'h1FE) !== 32'h006)
      $display("FAIL stall_reads: got rd_en mask %h required 006", m & 32'h1FE);
    else pass_cnt++;
    total_cnt++;
    if (f !== 9) $display("FAIL stall_first: got %0d required 9", f);
    else pass_cnt++;
  endtask

  task automatic test_toggle();
    int f, l, d, m;
    load_matrix(3);
    step(1'b1, 1'b1, 1'b0);
    run_readout("toggle", 2, 0, 0, f, l, d, m);
  endtask

  task automatic test_restart();
    int f, l, d, m;
    load_matrix(1);
    step(1'b1, 1'b1, 1'b0);
    run_readout("restart", 0, 4, 0, f, l, d, m);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0);
      total_cnt++;
      if ({busy, done, out_val, rd_en} !== 4'b0000)
        $display("FAIL restart_quiet: got %b required 0000", {busy, done, out_val, rd_en});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int f, l, d, m;
    load_matrix(1);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    total_cnt++;
    if ({busy, done, rd_en, out_val} !== 4'b0000 || pack_addr() !== '0 || pack_row() !== '0)
      $display("FAIL reset_mid: got ctrl=%b addr=%h row=%h required all 0",
               {busy, done, rd_en, out_val}, pack_addr(), pack_row());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0);
      total_cnt++;
      if ({busy, done, out_val} !== 3'b000)
        $display("FAIL reset_mid_quiet: got %b required 000", {busy, done, out_val});
      else pass_cnt++;
    end
    load_matrix(2);
    step(1'b1, 1'b1, 1'b0);
    run_readout("after_reset", 0, 0, 0, f, l, d, m);
    total_cnt++;
    if (f !== 3 || d !== 3 + N)
      $display("FAIL after_reset_latency: got first=%0d done=%0d required 3/%0d", f, d, 3 + N);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int f, l, d, m;
    load_matrix(1);
    step(1'b1, 1'b1, 1'b0);
    run_readout("b2b_A", 0, 0, 2, f, l, d, m);
    run_readout("b2b_B", 0, 0, 0, f, l, d, m);
    total_cnt++;
    if (f !== 3 || l !== 2 + N || d !== 3 + N)
      $display("FAIL b2b_latency: got first=%0d last=%0d done=%0d required 3/%0d/%0d", f, l, d, 2 + N, 3 + N);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int f, l, d, m;
    for (int i = 0; i < 4; i++) begin
      load_matrix(3);
      step(1'b1, 1'b1, 1'b0);
      run_readout("random", 3, 0, 0, f, l, d, m);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_rdy = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/transpose_read_controller.md
Name: transpose_read_controller

Overview:
- Read side of the skewed transpose memory.
- The write side stores input row r, element j, in bank (j+r) mod NUM_PE at address r.
- After a start pulse, this block issues per-bank diagonal read addresses, un-rotates the returned bank data, and emits the transposed rows (column 0 first) on a valid/ready stream into the downstream PE array.
- It holds a 2-entry skid FIFO to absorb the 1-cycle bank read latency under backpressure.

Parameters:
DATA_WIDTH, 64, width of one matrix element
NUM_MG, 8, number of memory banks
NUM_PE, NUM_MG, elements per row; must equal NUM_MG and be a power of two >= 2
ADDR_WIDTH, $clog2(NUM_PE), bank address width (localparam)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  pulse: full matrix is resident in the banks; begin readout
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last output row handshakes
rd_en  output  1  bank read strobe for this cycle
read_addr  output  ADDR_WIDTH x NUM_MG  per-bank read address (unpacked array [0:NUM_MG-1])
read_data  input  DATA_WIDTH x NUM_MG  bank data, valid one cycle after rd_en
out_val  output  1  output_row valid
out_rdy  input  1  downstream accepts output_row
output_row  output  DATA_WIDTH x NUM_PE  transposed row (unpacked array [0:NUM_PE-1])

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, read_addr[*]=0, out_val=0, output_row[*]=0. FSM=IDLE, column counter=0, FIFO empty, in-flight flag=0.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ when start=1. The column counter is cleared.
  - READ -> DRAIN in the cycle after the read for column NUM_PE-1 is issued.
  - DRAIN -> IDLE when the FIFO is empty, nothing is in flight and the last row has handshaken. done pulses in the IDLE-entry cycle.
  - start while busy (READ/DRAIN) is ignored and has no side effects.
- Address generation for column c: read_addr[b] = (b - c) mod NUM_PE, computed by ADDR_WIDTH-bit truncating subtraction. When rd_en=0, read_addr holds its last value.
- Issue rule: in READ, rd_en=1 iff (fifo_count + inflight - pop) <= 1, where pop = out_val & out_rdy in that cycle. On issue, the column counter increments. The column tag is registered alongside the in-flight flag.
- Capture: in the cycle after rd_en, the rotated data is pushed into the FIFO: row[r] = read_data[(r + c_tag) mod NUM_PE]. The FIFO is 2 entries deep and can never overflow given the issue rule. Push and pop in the same cycle are both honoured.
- Output: out_val = FIFO non-empty. output_row = FIFO head, registered. While out_val=1 and out_rdy=0, output_row and out_val hold stable. Rows are emitted strictly in column order 0..NUM_PE-1.
- Latency:
  - start in cycle T: rd_en/read_addr for column 0 in T+1, read_data in T+2, out_val with row 0 in T+3.
  - With out_rdy held 1: one row per cycle, last row in T+2+NUM_PE, done in T+3+NUM_PE, busy low from T+3+NUM_PE.
- Wrap-around: the column counter wraps from NUM_PE-1 to 0 only on a new start. The address subtraction wraps mod NUM_PE.
- start in the same cycle as done: accepted; a new readout begins with the identical timing above.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight bank data is discarded, no done pulse is produced, and partially emitted matrices are not resumed.

Test Plan:
- Bank model preloaded with skewed A[r][c]=16*r+c (NUM_PE=8), start pulse, out_rdy=1 -> rows at T+3..T+10, row c = {c, 16+c, ..., 112+c}. done at T+11. Cycle T+1 read_addr = {0,1,...,7}; cycle T+2 = {7,0,...,6}.
- Same preload, out_rdy=0 for cycles T+3..T+8, then 1 -> out_val=1 and row 0 held stable. Exactly two reads issued before stall (rd_en in T+1,T+2 only). Resumes with rows 0..7 in order, no loss or duplication.
- out_rdy toggling 1,0,1,0... -> 8 rows in correct order; FIFO never exceeds 2; done one cycle after 8th handshake.
- start re-pulsed at T+4 during READ -> ignored; exactly 8 rows and one done.
- rst asserted at T+5 for one cycle -> next cycle all outputs 0, no done. New start yields a clean full matrix.
- start asserted in the done cycle with a second matrix B[r][c]=200+8*r+c -> back-to-back readout with identical latency; rows of B follow A without gap beyond the 3-cycle pipeline fill.
